// File: rtl/char_stream_source.sv
// -----------------------------------------------------------------------------
// char_stream_source
//
// Producer end of the character stream read by html_parser. Bytes arriving from
// an upstream byte source (UART/PS2 receiver) are buffered in a small FIFO and
// presented one at a time on char/char_valid. The parser may stall with pause.
// Once in_end has been seen and every buffered byte has been consumed, finished
// rises and stays high until reset.
//
// Ports
//   clock        system clock
//   resetn       synchronous reset, active low
//   in_data      upstream byte
//   in_valid     in_data valid this cycle
//   in_ready     FIFO accepts in_data this cycle
//   in_end       one-cycle pulse: no more bytes will follow
//   pause        parser stall; holds a presented character
//   char         current character, 8'h00 when char_valid is low
//   char_valid   char holds an unconsumed character
//   finished     document fully consumed after in_end (sticky)
//   char_count   characters consumed, saturating at 16'hFFFF
//   dbg_state_o  current FSM state (STREAM=0, DRAIN=1, DONE=2)
//
// Handshakes
//   Upstream: a byte transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on registered state, never on in_valid or pause.
//   A byte offered while in_ready is low is not taken; the source must hold it.
//   Downstream: a character is consumed on a rising edge where
//   char_valid && !pause. While char_valid && pause, char is held unchanged.
// -----------------------------------------------------------------------------
module char_stream_source #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_end,
    input  logic        pause,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        finished,
    output logic [15:0] char_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Registered state
    state_t            state_q,      state_d;
    logic [ADDR_W:0]   count_q,      count_d;
    logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [7:0]        char_q,       char_d;
    logic              char_valid_q, char_valid_d;
    logic              finished_q,   finished_d;
    logic [15:0]       char_count_q, char_count_d;

    // Storage is not reset: only entries between rd_ptr and wr_ptr are read.
    logic [7:0] mem_q [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic wr_en;
    logic consume;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);

    // Ready comes from registered count only, so a full FIFO refuses a byte
    // even when a pop frees a slot on the same edge.
    assign in_ready = ~fifo_full & (state_q == ST_STREAM);
    assign wr_en    = in_valid & in_ready;
    assign consume  = char_valid_q & ~pause;
    // The output register is refilled when it is empty or being consumed.
    // An empty output register is filled even during pause: pause only
    // freezes a character that is already presented.
    assign pop      = ~fifo_empty & (~char_valid_q | consume);

    always_comb begin
        state_d      = state_q;
        finished_d   = finished_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        char_d       = char_q;
        char_valid_d = char_valid_q;
        char_count_d = char_count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            char_d       = mem_q[rd_ptr_q];
            char_valid_d = 1'b1;
        end else if (consume) begin
            char_d       = 8'h00;
            char_valid_d = 1'b0;
        end

        if (consume && (char_count_q != 16'hFFFF)) begin
            char_count_d = char_count_q + 16'd1;
        end

        unique case (state_q)
            ST_STREAM: begin
                // A byte written on the same edge as in_end is kept, since
                // in_ready was still high for that edge.
                if (in_end) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !char_valid_q) begin
                    state_d    = ST_DONE;
                    finished_d = 1'b1;
                end
            end
            ST_DONE: begin
                finished_d   = 1'b1;
                char_d       = 8'h00;
                char_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_STREAM;
            finished_q   <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            char_q       <= 8'h00;
            char_valid_q <= 1'b0;
            char_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            finished_q   <= finished_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
            char_count_q <= char_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign char        = char_q;
    assign char_valid  = char_valid_q;
    assign finished    = finished_q;
    assign char_count  = char_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_char_stream_source.sv
// -----------------------------------------------------------------------------
// Testbench for char_stream_source: fixed vector table, hand-written corner
// sequences and a randomized phase, all compared every cycle against a
// queue-based reference model of the character stream.
// -----------------------------------------------------------------------------
module tb_char_stream_source;

    localparam int DEPTH = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clock;
    logic        resetn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_end;
    logic        pause;
    logic [7:0]  char;
    logic        char_valid;
    logic        finished;
    logic [15:0] char_count;
    logic [1:0]  dbg_state;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    char_stream_source #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_end      (in_end),
        .pause       (pause),
        .char        (char),
        .char_valid  (char_valid),
        .finished    (finished),
        .char_count  (char_count),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;
    int cycle_no;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cycle_no, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The stream is a queue of buffered bytes plus one presented character.
    logic [7:0] m_fifo[$];
    logic [7:0] m_char;
    bit         m_valid;
    bit         m_ending;   // in_end seen, no more bytes accepted
    bit         m_done;
    int         m_count;

    // Scoreboard: bytes accepted upstream, in the order they must be consumed.
    logic [7:0] exp_q[$];

    function automatic bit m_ready();
        return (m_fifo.size() < DEPTH) && !m_ending && !m_done;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_char   = 8'h00;
        m_valid  = 1'b0;
        m_ending = 1'b0;
        m_done   = 1'b0;
        m_count  = 0;
    endtask

    // One clock: scoreboard the DUT consumption, advance the model with the
    // current inputs, take the edge, compare DUT outputs to the model.
    task automatic tick();
        bit consume;
        bit wr;
        bit was_idle;
        if (resetn === 1'b1 && char_valid === 1'b1 && pause === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra (cycle %0d): got char %0h expected none", cycle_no, char);
            end else begin
                checks--;
                check("sb_order", {24'd0, char}, {24'd0, exp_q.pop_front()});
            end
        end

        if (!resetn) begin
            model_reset();
        end else begin
            consume  = m_valid && !pause;
            wr       = in_valid && m_ready();
            was_idle = (m_fifo.size() == 0) && !m_valid;
            if (m_fifo.size() > 0 && (!m_valid || consume)) begin
                m_char  = m_fifo.pop_front();
                m_valid = 1'b1;
            end else if (consume) begin
                m_char  = 8'h00;
                m_valid = 1'b0;
            end
            if (consume && m_count < 65535) m_count++;
            if (wr) begin
                m_fifo.push_back(in_data);
                exp_q.push_back(in_data);
            end
            if (m_ending && was_idle) m_done = 1'b1;
            else if (!m_ending && in_end) m_ending = 1'b1;
        end

        @(posedge clock);
        #1;
        cycle_no++;
        check("mdl_char",     {24'd0, char},       {24'd0, m_char});
        check("mdl_valid",    {31'd0, char_valid}, {31'd0, m_valid});
        check("mdl_ready",    {31'd0, in_ready},   {31'd0, m_ready()});
        check("mdl_finished", {31'd0, finished},   {31'd0, m_done});
        check("mdl_count",    {16'd0, char_count}, 32'(m_count));
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_end   = 1'b0;
        pause    = 1'b0;
        in_data  = 8'h00;
        tick();
        resetn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [7:0]  data;
        logic        endp;
        logic        pse;
        logic [7:0]  e_char;
        logic        e_valid;
        logic        e_ready;
        logic        e_fin;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[12];

    // ---------------- main test ----------------
    initial begin
        int b_edge;
        int fin_edge;
        int a_n;
        int b_n;
        bit accepted;

        checks   = 0;
        errors   = 0;
        cycle_no = 0;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_end   = 1'b0;
        pause    = 1'b0;
        in_data  = 8'h00;
        model_reset();

        // Rows: inputs for the edge, then outputs expected right after it.
        // "<b>" streamed with no pause, then in_end on an empty stream.
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'h62, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h3E, 1'b0, 1'b0, 8'h62, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3E, 1'b1, 1'b1, 1'b0, 16'd2};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[10] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};

        for (int i = 0; i < 12; i++) begin
            resetn   = tbl[i].rst_n;
            in_valid = tbl[i].vld;
            in_data  = tbl[i].data;
            in_end   = tbl[i].endp;
            pause    = tbl[i].pse;
            tick();
            check($sformatf("tbl%0d_char", i),  {24'd0, char},       {24'd0, tbl[i].e_char});
            check($sformatf("tbl%0d_valid", i), {31'd0, char_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d_ready", i), {31'd0, in_ready},   {31'd0, tbl[i].e_ready});
            check($sformatf("tbl%0d_fin", i),   {31'd0, finished},   {31'd0, tbl[i].e_fin});
            check($sformatf("tbl%0d_cnt", i),   {16'd0, char_count}, {16'd0, tbl[i].e_cnt});
        end
        in_valid = 1'b0;
        in_end   = 1'b0;
        pause    = 1'b0;

        // Fill while paused. The first byte moves into the output register,
        // so DEPTH+1 bytes are taken before in_ready drops.
        apply_reset();
        pause    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_data = 8'(8'h10 + i);
            tick();
        end
        in_data = 8'(8'h10 + DEPTH + 1);
        check("fill_ready", {31'd0, in_ready}, 32'd0);
        check("fill_char",  {24'd0, char},     32'h10);
        tick();
        tick();
        check("hold_char",  {24'd0, char},     32'h10);
        check("hold_ready", {31'd0, in_ready}, 32'd0);
        pause = 1'b0;
        for (int k = 0; k < 40 && in_valid; k++) begin
            accepted = m_ready();
            tick();
            if (accepted) in_valid = 1'b0;
        end
        for (int k = 0; k < 25; k++) tick();
        check("fill_total", {16'd0, char_count}, 32'(DEPTH + 2));
        check("fill_drained", 32'(exp_q.size()), 32'd0);

        // 'A','B', in_end, pause toggling: each char held two cycles and
        // finished rising one edge after 'B' is consumed.
        apply_reset();
        b_edge   = -100;
        fin_edge = -1;
        a_n      = 0;
        b_n      = 0;
        in_valid = 1'b1;
        in_data  = 8'h41;
        tick();
        in_data = 8'h42;
        tick();
        if (char_valid && char == 8'h41) a_n++;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_end = (k == 0);
            pause  = (k % 2 == 0);
            if (char_valid && !pause && char == 8'h42) b_edge = cycle_no + 1;
            tick();
            if (char_valid && char == 8'h41) a_n++;
            if (char_valid && char == 8'h42) b_n++;
            if (finished && fin_edge < 0) fin_edge = cycle_no;
        end
        in_end = 1'b0;
        pause  = 1'b0;
        check("ab_a_held",   32'(a_n), 32'd2);
        check("ab_b_held",   32'(b_n), 32'd2);
        check("ab_fin_edge", 32'(fin_edge - b_edge), 32'd1);
        tick();
        check("ab_sticky",   {31'd0, finished}, 32'd1);

        // Reset with bytes buffered discards everything.
        apply_reset();
        pause    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        tick();
        check("rst_valid", {31'd0, char_valid}, 32'd0);
        check("rst_char",  {24'd0, char},       32'd0);
        check("rst_count", {16'd0, char_count}, 32'd0);
        check("rst_ready", {31'd0, in_ready},   32'd1);
        resetn = 1'b1;
        pause  = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("rst_empty", {31'd0, char_valid}, 32'd0);

        // Randomized traffic with occasional in_end and reset.
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            resetn   = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = 8'($urandom_range(0, 255));
            pause    = ($urandom_range(0, 99) < 30);
            in_end   = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
